// File: rtl/alu_arb_pkg.sv
// Shared types and opcode decode for the ALU arbiter: FSM states, one-hot opcode
// patterns and the 3-bit ALU operation codes they map to.
package alu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [5:0] OPC_0 = 6'b000000;
  localparam logic [5:0] OPC_1 = 6'b100000;
  localparam logic [5:0] OPC_2 = 6'b010000;
  localparam logic [5:0] OPC_3 = 6'b001000;
  localparam logic [5:0] OPC_4 = 6'b000100;
  localparam logic [5:0] OPC_5 = 6'b000010;
  localparam logic [5:0] OPC_6 = 6'b000001;

  localparam logic [2:0] OP_0       = 3'b000;
  localparam logic [2:0] OP_1       = 3'b001;
  localparam logic [2:0] OP_2       = 3'b010;
  localparam logic [2:0] OP_3       = 3'b011;
  localparam logic [2:0] OP_4       = 3'b100;
  localparam logic [2:0] OP_5       = 3'b101;
  localparam logic [2:0] OP_6       = 3'b110;
  localparam logic [2:0] OP_ILLEGAL = 3'b111;

  function automatic logic [2:0] op_decode(input logic [5:0] opc);
    case (opc)
      OPC_0:   return OP_0;
      OPC_1:   return OP_1;
      OPC_2:   return OP_2;
      OPC_3:   return OP_3;
      OPC_4:   return OP_4;
      OPC_5:   return OP_5;
      OPC_6:   return OP_6;
      default: return OP_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_pick.sv
// Combinational round-robin selector: grants the first set bit of req at or
// above ptr, wrapping modulo N. Returns the one-hot grant and its index.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          found
);

  logic [IW-1:0] cand;

  always_comb begin
    // NOTE: every output gets a default before the search so no path leaves it unassigned (no latch).
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < N; i++) begin
      cand = IW'((int'(ptr) + i) % N);
      if (!found && req[cand]) begin
        grant[cand] = 1'b1;
        idx         = cand;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between NUM_REQ requesters with round-robin arbitration.
// Define ALU_ARB_ILLEGAL_OP_EN to answer illegal opcodes directly (rsp_err) instead of issuing them.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int ALU_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [6*NUM_REQ-1:0]      req_opcode,
  input  logic [DATA_W*NUM_REQ-1:0] req_a,
  input  logic [DATA_W*NUM_REQ-1:0] req_b,
  output logic [2:0]                alu_operation,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  input  logic [DATA_W-1:0]         alu_result,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_err,
  output logic                      busy
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(ALU_LAT + 1);

  state_e              state_q, state_d;
  logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]       id_q, id_d;
  logic [2:0]          op_q, op_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_err_q, rsp_err_d;

  logic [NUM_REQ-1:0]  pick_grant;
  logic [IW-1:0]       pick_idx;
  logic                pick_found;
  logic [5:0]          win_opc;
  logic [2:0]          win_op;

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign win_opc = req_opcode[int'(pick_idx)*6 +: 6];
  assign win_op  = op_decode(win_opc);

  // Ready is a pure function of the arbitration so the handshake closes in the same cycle.
  assign req_ready = (state_q == IDLE && rst_n) ? pick_grant : '0;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    id_d        = id_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    cnt_d       = cnt_q;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          id_d     = pick_idx;
          rr_ptr_d = (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + IW'(1);
`ifdef ALU_ARB_ILLEGAL_OP_EN
          if (win_op == OP_ILLEGAL) begin
            state_d     = RESP;
            rsp_valid_d = pick_grant;
            rsp_data_d  = '0;
            rsp_err_d   = 1'b1;
          end else
`endif
          begin
            op_d    = win_op;
            a_d     = req_a[int'(pick_idx)*DATA_W +: DATA_W];
            b_d     = req_b[int'(pick_idx)*DATA_W +: DATA_W];
            cnt_d   = CW'(ALU_LAT);
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d           = RESP;
          rsp_data_d        = alu_result;
          rsp_valid_d[id_q] = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      op_q        <= OP_0;
      a_q         <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value of its neighbours.
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      id_q        <= id_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign alu_operation = op_q;
  assign alu_a         = a_q;
  assign alu_b         = b_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_err       = rsp_err_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table, multi-cycle corner
// sequences (ALU_LAT=1 and ALU_LAT=3 instances) and a randomized run against a timing model.
module tb_alu_arbiter;

  localparam int N = 4;
  localparam int W = 32;
`ifdef ALU_ARB_ILLEGAL_OP_EN
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance with ALU_LAT=1
  logic [N-1:0]   req_valid, req_ready, rsp_valid;
  logic [6*N-1:0] req_opcode;
  logic [W*N-1:0] req_a, req_b;
  logic [2:0]     alu_operation;
  logic [W-1:0]   alu_a, alu_b, alu_result, rsp_data;
  logic           rsp_err, busy;

  // Instance with ALU_LAT=3
  logic [N-1:0]   s_valid, s_ready, s_rsp_valid;
  logic [6*N-1:0] s_opcode;
  logic [W*N-1:0] s_a, s_b;
  logic [2:0]     s_alu_operation;
  logic [W-1:0]   s_alu_a, s_alu_b, s_alu_result, s_rsp_data;
  logic           s_rsp_err, s_busy;

  assign alu_result   = alu_fn(alu_operation, alu_a, alu_b);
  assign s_alu_result = alu_fn(s_alu_operation, s_alu_a, s_alu_b);

  alu_arbiter #(.NUM_REQ(N), .DATA_W(W), .ALU_LAT(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_a(req_a), .req_b(req_b),
    .alu_operation(alu_operation), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
  );

  alu_arbiter #(.NUM_REQ(N), .DATA_W(W), .ALU_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(s_valid), .req_ready(s_ready), .req_opcode(s_opcode),
    .req_a(s_a), .req_b(s_b),
    .alu_operation(s_alu_operation), .alu_a(s_alu_a), .alu_b(s_alu_b), .alu_result(s_alu_result),
    .rsp_valid(s_rsp_valid), .rsp_data(s_rsp_data), .rsp_err(s_rsp_err), .busy(s_busy)
  );

  int checks   = 0;
  int failures = 0;

  // Stand-in ALU so every operation code yields a distinct, predictable result.
  function automatic logic [W-1:0] alu_fn(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      3'd0:    return a;
      3'd1:    return a + b;
      3'd2:    return a - b;
      3'd3:    return a & b;
      3'd4:    return a | b;
      3'd5:    return a ^ b;
      3'd6:    return ~a;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Zero maps to 0, a single set bit at position k maps to 6-k, anything else is illegal.
  function automatic logic [2:0] ref_decode(input logic [5:0] opc);
    if (opc == 6'd0) return 3'd0;
    if ($countones(opc) == 1)
      for (int k = 0; k < 6; k++)
        if (opc[k]) return 3'(6 - k);
    return 3'd7;
  endfunction

  function automatic logic [N-1:0] onehot(input int j);
    logic [N-1:0] r;
    r    = '0;
    r[j] = 1'b1;
    return r;
  endfunction

  function automatic int oh_index(input logic [N-1:0] v);
    for (int k = 0; k < N; k++)
      if (v[k]) return k;
    return -1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [5:0] opc, input logic [W-1:0] a, input logic [W-1:0] b);
    req_valid[i]           = v;
    req_opcode[i*6 +: 6]   = opc;
    req_a[i*W +: W]        = a;
    req_b[i*W +: W]        = b;
  endtask

  task automatic set_sreq(input int i, input logic v, input logic [5:0] opc, input logic [W-1:0] a, input logic [W-1:0] b);
    s_valid[i]           = v;
    s_opcode[i*6 +: 6]   = opc;
    s_a[i*W +: W]        = a;
    s_b[i*W +: W]        = b;
  endtask

  // Bounded wait for a ready bit; returns 0 if the budget expires.
  task automatic wait_rdy(input bit use3, output logic [N-1:0] r);
    r = '0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      r = use3 ? s_ready : req_ready;
      if (r != '0) break;
    end
  endtask

  task automatic do_reset();
    req_valid = '0;
    s_valid   = '0;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  typedef struct {
    int         id;
    logic [5:0] opc;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0] exp_op;
    logic [W-1:0] exp_a;
    logic [W-1:0] exp_data;
    logic       exp_err;
    int         exp_lat;
  } vec_t;

  vec_t vecs[9];

  task automatic run_vec(input int vi, input vec_t v);
    logic [N-1:0] r;
    @(posedge clk);
    #1 set_req(v.id, 1'b1, v.opc, v.a, v.b);
    wait_rdy(1'b0, r);
    check($sformatf("v%0d_ready", vi), 64'(r), 64'(onehot(v.id)));
    @(posedge clk);
    #1 req_valid[v.id] = 1'b0;
    @(negedge clk);
    check($sformatf("v%0d_alu_op", vi), 64'(alu_operation), 64'(v.exp_op));
    check($sformatf("v%0d_alu_a", vi), 64'(alu_a), 64'(v.exp_a));
    for (int k = 1; k <= v.exp_lat; k++) begin
      if (k > 1) @(negedge clk);
      if (k == v.exp_lat) begin
        check($sformatf("v%0d_rsp_valid", vi), 64'(rsp_valid), 64'(onehot(v.id)));
        check($sformatf("v%0d_rsp_data", vi), 64'(rsp_data), 64'(v.exp_data));
        check($sformatf("v%0d_rsp_err", vi), 64'(rsp_err), 64'(v.exp_err));
      end else begin
        check($sformatf("v%0d_rsp_early", vi), 64'(rsp_valid), 64'(0));
      end
    end
    @(negedge clk);
    check($sformatf("v%0d_idle", vi), {62'd0, busy, |rsp_valid}, 64'(0));
  endtask

  int gid[$];
  int gcyc[$];

  initial begin
    logic [N-1:0] r;
    int           max_ones;
    bit           saw_bad, saw_good;

    // Directed vectors for the ALU_LAT=1 instance.
    vecs[0] = '{0, 6'b100000, 32'd5,         32'd3,    3'd1, 32'd5,         32'd8,         1'b0, 2};
    vecs[1] = '{0, 6'b000000, 32'd7,         32'd1,    3'd0, 32'd7,         32'd7,         1'b0, 2};
    vecs[2] = '{1, 6'b010000, 32'd10,        32'd4,    3'd2, 32'd10,        32'd6,         1'b0, 2};
    vecs[3] = '{2, 6'b001000, 32'hF0,        32'h3C,   3'd3, 32'hF0,        32'h30,        1'b0, 2};
    vecs[4] = '{3, 6'b000100, 32'hF0,        32'h0F,   3'd4, 32'hF0,        32'hFF,        1'b0, 2};
    vecs[5] = '{1, 6'b000010, 32'hFF,        32'h0F,   3'd5, 32'hFF,        32'hF0,        1'b0, 2};
    vecs[6] = '{2, 6'b000001, 32'h0000_FFFF, 32'd0,    3'd6, 32'h0000_FFFF, 32'hFFFF_0000, 1'b0, 2};
`ifdef ALU_ARB_ILLEGAL_OP_EN
    vecs[7] = '{1, 6'b110000, 32'd9,         32'd9,    3'd6, 32'h0000_FFFF, 32'd0,         1'b1, 1};
    vecs[8] = '{3, 6'b111111, 32'd1,         32'd2,    3'd6, 32'h0000_FFFF, 32'd0,         1'b1, 1};
`else
    vecs[7] = '{1, 6'b110000, 32'd9,         32'd9,    3'd7, 32'd9,         32'hDEAD_BEEF, 1'b0, 2};
    vecs[8] = '{3, 6'b111111, 32'd1,         32'd2,    3'd7, 32'd1,         32'hDEAD_BEEF, 1'b0, 2};
`endif

    req_valid = '0; req_opcode = '0; req_a = '0; req_b = '0;
    s_valid   = '0; s_opcode   = '0; s_a   = '0; s_b   = '0;

    // Reset values, with requests pending to confirm ready is forced low.
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 6'b100000, 32'd1, 32'd1);
    repeat (2) @(negedge clk);
    check("rst_ready", 64'(req_ready), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_alu_op", 64'(alu_operation), 64'(0));
    check("rst_alu_a", 64'(alu_a), 64'(0));
    check("rst_alu_b", 64'(alu_b), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_rsp_data", 64'(rsp_data), 64'(0));
    check("rst_rsp_err", 64'(rsp_err), 64'(0));
    req_valid = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int vi = 0; vi < 9; vi++) run_vec(vi, vecs[vi]);

    // All four requesters valid continuously from a fresh pointer.
    do_reset();
    @(posedge clk);
    #1 for (int i = 0; i < N; i++) set_req(i, 1'b1, 6'b100000, 32'(i), 32'd1);
    max_ones = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if ($countones(req_ready) > max_ones) max_ones = $countones(req_ready);
      if (req_ready != '0) begin
        gid.push_back(oh_index(req_ready));
        gcyc.push_back(c);
      end
    end
    check("rr_max_ready_bits", 64'(max_ones), 64'(1));
    check("rr_grant_count", 64'(gid.size()), 64'(6));
    if (gid.size() >= 5) begin
      for (int k = 0; k < 5; k++) begin
        check($sformatf("rr_order%0d", k), 64'(gid[k]), 64'(k % N));
        if (k > 0) check($sformatf("rr_spacing%0d", k), 64'(gcyc[k] - gcyc[k-1]), 64'(3));
      end
    end
    @(posedge clk);
    #1 req_valid = '0;
    repeat (4) @(posedge clk);

    // Requester 3 withdraws during BUSY; requester 1 must be served next.
    do_reset();
    @(posedge clk);
    #1 set_req(2, 1'b1, 6'b010000, 32'd20, 32'd5);
    wait_rdy(1'b0, r);
    check("wd_first_ready", 64'(r), 64'(4'b0100));
    @(posedge clk);
    #1 begin
      req_valid[2] = 1'b0;
      set_req(3, 1'b1, 6'b100000, 32'd1, 32'd1);
      set_req(1, 1'b1, 6'b001000, 32'hFF, 32'h0F);
    end
    @(negedge clk);
    check("wd_busy_ready", 64'(req_ready), 64'(0));
    @(posedge clk);
    #1 req_valid[3] = 1'b0;
    @(negedge clk);
    check("wd_rsp2", 64'(rsp_valid), 64'(4'b0100));
    check("wd_rsp2_data", 64'(rsp_data), 64'(32'd15));
    @(negedge clk);
    check("wd_grant1", 64'(req_ready), 64'(4'b0010));
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    saw_bad = 1'b0; saw_good = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rsp_valid[3]) saw_bad = 1'b1;
      if (rsp_valid[1]) saw_good = 1'b1;
    end
    check("wd_no_rsp3", 64'(saw_bad), 64'(0));
    check("wd_rsp1", 64'(saw_good), 64'(1));

    // ALU_LAT=3: operands held three cycles, response four cycles after accept.
    do_reset();
    @(posedge clk);
    #1 set_sreq(2, 1'b1, 6'b000001, 32'h00FF_00FF, 32'd7);
    wait_rdy(1'b1, r);
    check("lat3_ready", 64'(r), 64'(4'b0100));
    @(posedge clk);
    #1 s_valid[2] = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k <= 3) begin
        check($sformatf("lat3_op_c%0d", k), 64'(s_alu_operation), 64'(3'b110));
        check($sformatf("lat3_a_c%0d", k), 64'(s_alu_a), 64'(32'h00FF_00FF));
        check($sformatf("lat3_norsp_c%0d", k), 64'(s_rsp_valid), 64'(0));
      end else begin
        check("lat3_rsp", 64'(s_rsp_valid), 64'(4'b0100));
        check("lat3_data", 64'(s_rsp_data), 64'(32'hFF00_FF00));
      end
    end
    repeat (2) @(posedge clk);

    // Reset in BUSY discards the op and returns the pointer to requester 0.
    do_reset();
    @(posedge clk);
    #1 set_sreq(2, 1'b1, 6'b010000, 32'd9, 32'd4);
    wait_rdy(1'b1, r);
    check("mid_ready", 64'(r), 64'(4'b0100));
    @(posedge clk);
    #1 s_valid[2] = 1'b0;
    @(negedge clk);
    check("mid_busy", 64'(s_busy), 64'(1));
    #1 begin
      rst_n = 1'b0;
      set_sreq(3, 1'b1, 6'b100000, 32'd3, 32'd3);
      set_sreq(0, 1'b1, 6'b100000, 32'd4, 32'd4);
    end
    #1 begin
      check("mid_rst_busy", 64'(s_busy), 64'(0));
      check("mid_rst_op", 64'(s_alu_operation), 64'(0));
      check("mid_rst_a", 64'(s_alu_a), 64'(0));
      check("mid_rst_ready", 64'(s_ready), 64'(0));
      check("mid_rst_rsp", 64'(s_rsp_valid), 64'(0));
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("mid_next_grant0", 64'(s_ready), 64'(4'b0001));
    @(posedge clk);
    #1 s_valid = '0;
    saw_bad = 1'b0; saw_good = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (s_rsp_valid[3:1] != '0) saw_bad = 1'b1;
      if (s_rsp_valid[0]) saw_good = 1'b1;
    end
    check("mid_no_stale_rsp", 64'(saw_bad), 64'(0));
    check("mid_rsp0", 64'(saw_good), 64'(1));

    // Randomized traffic against a timing/arbitration model.
    begin
      int           m_ptr, free_cyc, rsp_cyc, rsp_id, acc, j, r_sel;
      logic [W-1:0] rsp_d, m_a, m_b, pa, pb;
      logic         rsp_e;
      logic [2:0]   m_op, dec;
      logic [5:0]   popc;
      logic [N-1:0] exp_ready;

      do_reset();
      m_ptr = 0; free_cyc = 0; rsp_cyc = -1; rsp_id = 0; acc = -1;
      rsp_d = '0; rsp_e = 1'b0; m_op = 3'd0; m_a = '0; m_b = '0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        @(posedge clk);
        #1 begin
          if (acc >= 0) req_valid[acc] = 1'b0;
          for (int i = 0; i < N; i++) begin
            if (req_valid[i]) begin
              if ($urandom_range(0, 19) == 0) req_valid[i] = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
              r_sel = int'($urandom_range(0, 9));
              if (r_sel == 0)      popc = 6'd0;
              else if (r_sel <= 6) popc = 6'(1 << (6 - r_sel));
              else                 popc = 6'($urandom);
              set_req(i, 1'b1, popc, $urandom, $urandom);
            end
          end
        end
        acc = -1;
        @(negedge clk);
        exp_ready = '0;
        j = -1;
        if (cyc >= free_cyc) begin
          for (int k = 0; k < N; k++)
            if (j < 0 && req_valid[(m_ptr + k) % N]) j = (m_ptr + k) % N;
          if (j >= 0) exp_ready = onehot(j);
        end
        check("rnd_ready", 64'(req_ready), 64'(exp_ready));
        check("rnd_busy", 64'(busy), 64'(cyc < free_cyc));
        check("rnd_rsp_valid", 64'(rsp_valid), 64'((cyc == rsp_cyc) ? onehot(rsp_id) : '0));
        if (cyc == rsp_cyc) begin
          check("rnd_rsp_data", 64'(rsp_data), 64'(rsp_d));
          check("rnd_rsp_err", 64'(rsp_err), 64'(rsp_e));
        end
        check("rnd_alu", {rsp_err & ~rsp_e, alu_operation, alu_a, alu_b[W-1:4]} ^ 64'(0),
              {1'b0, m_op, m_a, m_b[W-1:4]});
        if (j >= 0) begin
          popc = req_opcode[j*6 +: 6];
          pa   = req_a[j*W +: W];
          pb   = req_b[j*W +: W];
          dec  = ref_decode(popc);
          if (ILL_EN && dec == 3'd7) begin
            rsp_cyc = cyc + 1;
            rsp_d   = '0;
            rsp_e   = 1'b1;
          end else begin
            rsp_cyc = cyc + 2;
            rsp_d   = alu_fn(dec, pa, pb);
            rsp_e   = 1'b0;
            m_op    = dec;
            m_a     = pa;
            m_b     = pb;
          end
          rsp_id   = j;
          free_cyc = rsp_cyc + 1;
          m_ptr    = (j + 1) % N;
          acc      = j;
        end
      end
      req_valid = '0;
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
